// File: rtl/caesar_decrypt_stream.sv
// Streaming Caesar decryptor for ASCII digits/letters with a single-entry output register.
// A message starts with key_load in IDLE and ends when the byte marked in_last leaves the block.
module caesar_decrypt_stream #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       shift_value,
   input  logic             key_load,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             key_error,
   output logic [CNT_W-1:0] char_count,
   output logic [1:0]       state_dbg
);

   // Handshake: a byte moves on any rising edge where valid && ready on that
   // side; the producer holds data stable while valid is high and ready is low.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] key;
   logic       in_xfer;
   logic       out_xfer;

   assign in_ready  = (state == RUN) && (!out_valid || out_ready);
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   // Subtraction is done at 9 bits so a byte below the key cannot wrap.
   function automatic logic [7:0] decrypt_byte(input logic [7:0] c, input logic [3:0] k);
      logic [8:0] diff;
      logic [7:0] res;
      diff = {1'b0, c} - {5'd0, k};
      res  = c;
      if (c >= 8'd48 && c <= 8'd57)
         res = (diff < 9'd48) ? diff[7:0] + 8'd10 : diff[7:0];
      else if (c >= 8'd65 && c <= 8'd90)
         res = (diff < 9'd65) ? diff[7:0] + 8'd26 : diff[7:0];
      else if (c >= 8'd97 && c <= 8'd122)
         res = (diff < 9'd97) ? diff[7:0] + 8'd26 : diff[7:0];
      return res;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         key        <= 4'd0;
         key_error  <= 1'b0;
         char_count <= '0;
         out_valid  <= 1'b0;
         out_data   <= 8'd0;
         out_last   <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (key_load) begin
                  // Out-of-range keys fall back to pass-through and flag the error.
                  if (shift_value > 8'd9) begin
                     key       <= 4'd0;
                     key_error <= 1'b1;
                  end else begin
                     key       <= shift_value[3:0];
                     key_error <= 1'b0;
                  end
                  char_count <= '0;
                  state      <= RUN;
               end
            end
            RUN: begin
               if (in_xfer) begin
                  out_valid <= 1'b1;
                  out_data  <= decrypt_byte(in_data, key);
                  out_last  <= in_last;
                  if (char_count != {CNT_W{1'b1}})
                     char_count <= char_count + {{(CNT_W-1){1'b0}}, 1'b1};
                  if (in_last)
                     state <= DRAIN;
               end else if (out_xfer) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end
            end
            DRAIN: begin
               if (out_xfer && out_last) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_caesar_decrypt_stream.sv
// Bench for caesar_decrypt_stream: directed vector table, hand-written corner sequences,
// and randomized messages scored against a modular-arithmetic reference model.
module tb_caesar_decrypt_stream;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       shift_value;
   logic             key_load;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_last;
   logic             in_ready;
   logic             out_valid;
   logic [7:0]       out_data;
   logic             out_last;
   logic             out_ready;
   logic             busy;
   logic             done;
   logic             key_error;
   logic [CNT_W-1:0] char_count;
   logic [1:0]       state_dbg;

   caesar_decrypt_stream #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .shift_value(shift_value), .key_load(key_load),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .busy(busy), .done(done), .key_error(key_error), .char_count(char_count),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] ref_dec(input logic [7:0] c, input logic [7:0] k);
      int ke, ci;
      ke = (k > 8'd9) ? 0 : int'(k);
      ci = int'(c);
      if (ci >= 48 && ci <= 57)  return 8'(48 + (ci - 48 + 10 - ke) % 10);
      if (ci >= 65 && ci <= 90)  return 8'(65 + (ci - 65 + 26 - ke) % 26);
      if (ci >= 97 && ci <= 122) return 8'(97 + (ci - 97 + 26 - ke) % 26);
      return c;
   endfunction

   function automatic logic [7:0] enc(input logic [7:0] p, input int k);
      int pi;
      pi = int'(p);
      if (pi >= 48 && pi <= 57)  return 8'(48 + (pi - 48 + k) % 10);
      if (pi >= 65 && pi <= 90)  return 8'(65 + (pi - 65 + k) % 26);
      if (pi >= 97 && pi <= 122) return 8'(97 + (pi - 97 + k) % 26);
      return p;
   endfunction

   // ---------------- out_ready driver ----------------
   int rdy_mode = 0;  // 0: always ready, 1: random, 2: manual
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #3;
         if (rdy_mode == 1)      out_ready = ($urandom_range(0, 3) != 0);
         else if (rdy_mode == 0) out_ready = 1'b1;
      end
   end

   // ---------------- scoreboard / monitor ----------------
   logic [8:0] exp_q[$];
   logic       mon_en = 1'b0;
   logic       prev_stall = 1'b0;
   logic [8:0] prev_word = '0;
   logic       prev_last_xfer = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (prev_stall) begin
               check("hold_valid", out_valid, 1);
               check("hold_data", {out_last, out_data}, prev_word);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) check("unexpected_output", {out_last, out_data}, 32'hFFFF);
               else check("out_byte", {out_last, out_data}, exp_q.pop_front());
            end
            if (done || prev_last_xfer) check("done_pulse", done, prev_last_xfer);
            prev_stall     = out_valid && !out_ready;
            prev_word      = {out_last, out_data};
            prev_last_xfer = out_valid && out_ready && out_last;
         end else begin
            prev_stall     = 1'b0;
            prev_last_xfer = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic [7:0] msg_q[$];
   logic [7:0] exp_msg_q[$];
   int t_start, t_done;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic load_key(input logic [7:0] k);
      shift_value = k;
      key_load    = 1'b1;
      tick();
      key_load    = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      logic hs;
      int   n;
      in_valid = 1'b1; in_data = d; in_last = last;
      hs = 1'b0; n = 0;
      while (!hs && n < 200) begin
         @(negedge clk);
         hs = in_ready;
         tick();
         n++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      if (!hs) check("send_timeout", 0, 1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (n < 1000) begin
         @(negedge clk);
         if (done) break;
         n++;
      end
      t_done = cyc;
      check("done_seen", done, 1);
      check("idle_after_done", busy, 0);
      tick();
   endtask

   task automatic run_msg(input logic [7:0] k, input int stall_at, input int reload_at);
      int n, saved;
      n = msg_q.size();
      load_key(k);
      check("key_error", key_error, (k > 8'd9));
      t_start = cyc;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({(i == n - 1), exp_msg_q[i]});
         if (i == reload_at) begin
            key_load = 1'b1; shift_value = k ^ 8'h05;
         end
         if (i == stall_at) begin
            saved = rdy_mode; rdy_mode = 2; out_ready = 1'b0;
            fork
               send_byte(msg_q[i], (i == n - 1));
               begin
                  repeat (4) begin
                     @(negedge clk);
                     check("stall_in_ready", in_ready, 0);
                  end
                  @(posedge clk); #2;
                  out_ready = 1'b1;
               end
            join
            rdy_mode = saved;
         end else begin
            send_byte(msg_q[i], (i == n - 1));
         end
         key_load = 1'b0;
      end
      wait_done();
      check("char_count", char_count, (n > 255) ? 255 : n);
      check("queue_empty", exp_q.size(), 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] key;
      logic [7:0] din;
      logic [7:0] dout;
      logic       err;
   } vec_t;
   vec_t vecs[18];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{8'd3,  "A", "X", 1'b0};
      vecs[1]  = '{8'd3,  "a", "x", 1'b0};
      vecs[2]  = '{8'd3,  "1", "8", 1'b0};
      vecs[3]  = '{8'd3,  "!", "!", 1'b0};
      vecs[4]  = '{8'd12, "Z", "Z", 1'b1};
      vecs[5]  = '{8'd12, "z", "z", 1'b1};
      vecs[6]  = '{8'd12, "9", "9", 1'b1};
      vecs[7]  = '{8'd0,  "q", "q", 1'b0};
      vecs[8]  = '{8'd9,  "0", "1", 1'b0};
      vecs[9]  = '{8'd9,  "J", "A", 1'b0};
      vecs[10] = '{8'd1,  "a", "z", 1'b0};
      vecs[11] = '{8'd5,  8'hFF, 8'hFF, 1'b0};
      vecs[12] = '{8'd9,  "/", "/", 1'b0};
      vecs[13] = '{8'd9,  ":", ":", 1'b0};
      vecs[14] = '{8'd9,  "@", "@", 1'b0};
      vecs[15] = '{8'd9,  "[", "[", 1'b0};
      vecs[16] = '{8'd9,  "{", "{", 1'b0};
      vecs[17] = '{8'd255, "m", "m", 1'b1};

      rst = 1'b1; shift_value = 8'd0; key_load = 1'b0;
      in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_key_error", key_error, 0);
      check("rst_char_count", char_count, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // IDLE must ignore data until a key arrives
      in_valid = 1'b1; in_data = "K"; in_last = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("idle_in_ready", in_ready, 0);
         check("idle_out_valid", out_valid, 0);
      end
      tick();
      in_valid = 1'b0; in_last = 1'b0;

      // single-byte messages from the table
      for (int i = 0; i < 18; i++) begin
         load_key(vecs[i].key);
         check("vec_key_error", key_error, vecs[i].err);
         in_valid = 1'b1; in_data = vecs[i].din; in_last = 1'b1;
         tick();
         in_valid = 1'b0; in_last = 1'b0;
         @(negedge clk);
         check("vec_out_valid", out_valid, 1);
         check("vec_out_data", out_data, vecs[i].dout);
         check("vec_out_last", out_last, 1);
         check("vec_char_count", char_count, 1);
         @(negedge clk);
         check("vec_done", done, 1);
         check("vec_busy", busy, 0);
         tick();
      end
      check("count_held_in_idle", char_count, 1);
      check("key_error_held_in_idle", key_error, 1);

      mon_en = 1'b1;

      // KHOOR with key 3 at full rate
      msg_q = '{"K", "H", "O", "O", "R"};
      exp_msg_q = '{"H", "E", "L", "L", "O"};
      run_msg(8'd3, -1, -1);
      check("khoor_cycles", t_done - t_start, 6);

      // every alphanumeric through encryptor then decryptor, key 9
      msg_q.delete(); exp_msg_q.delete();
      for (int c = 0; c < 256; c++) begin
         if ((c >= 48 && c <= 57) || (c >= 65 && c <= 90) || (c >= 97 && c <= 122)) begin
            msg_q.push_back(enc(8'(c), 9));
            exp_msg_q.push_back(8'(c));
         end
      end
      check("alnum_count", msg_q.size(), 62);
      run_msg(8'd9, -1, 20);

      // downstream stall of four cycles mid-stream
      msg_q = '{"D", "f", "7", "Q", "z", "."};
      exp_msg_q.delete();
      foreach (msg_q[i]) exp_msg_q.push_back(ref_dec(msg_q[i], 8'd4));
      run_msg(8'd4, 3, -1);

      // key 12: pass-through with error flag
      msg_q = '{"Z", "z", "9"};
      exp_msg_q = '{"Z", "z", "9"};
      run_msg(8'd12, -1, -1);

      // char_count saturation on a long message
      msg_q.delete(); exp_msg_q.delete();
      for (int i = 0; i < 300; i++) begin
         msg_q.push_back(8'($urandom_range(0, 255)));
         exp_msg_q.push_back(ref_dec(msg_q[i], 8'd7));
      end
      run_msg(8'd7, -1, -1);

      // randomized messages with random back-pressure
      rdy_mode = 1;
      for (int m = 0; m < 10; m++) begin
         logic [7:0] k;
         int len;
         k   = 8'($urandom_range(0, 15));
         len = $urandom_range(2, 12);
         msg_q.delete(); exp_msg_q.delete();
         for (int i = 0; i < len; i++) begin
            msg_q.push_back(8'($urandom_range(0, 255)));
            exp_msg_q.push_back(ref_dec(msg_q[i], k));
         end
         run_msg(k, (m % 3 == 0) ? 1 : -1, (m % 3 == 1) ? len - 1 : -1);
      end
      rdy_mode = 0;
      repeat (2) tick();

      // reset while the output register is full
      mon_en = 1'b0;
      load_key(8'd12);
      send_byte("D", 1'b0);
      #1;
      check("pre_rst_out_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_out_last", out_last, 0);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_key_error", key_error, 0);
      check("mid_rst_char_count", char_count, 0);
      tick();
      rst = 1'b0;
      in_valid = 1'b1; in_data = "X"; in_last = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_in_ready", in_ready, 0);
         check("post_rst_out_valid", out_valid, 0);
         check("post_rst_done", done, 0);
      end
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      exp_q.delete();
      mon_en = 1'b1;

      // recovery after reset
      msg_q = '{"E", "b", "3"};
      exp_msg_q.delete();
      foreach (msg_q[i]) exp_msg_q.push_back(ref_dec(msg_q[i], 8'd2));
      run_msg(8'd2, -1, -1);

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/caesar_decrypt_stream.md
CAESAR_DECRYPT_STREAM -- requirements
Module: caesar_decrypt_stream

Interface
REQ-001 Parameter: CNT_W, default 8, width of char_count.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 shift_value  input  8  decryption key; sampled only on key_load.
REQ-005 key_load  input  1  start-of-message strobe; latches shift_value.
REQ-006 in_valid  input  1  ciphertext byte present.
REQ-007 in_data  input  8  ciphertext ASCII byte.
REQ-008 in_last  input  1  marks final byte of message; qualified by in_valid.
REQ-009 in_ready  output  1  block can accept a byte this cycle.
REQ-010 out_valid  output  1  plaintext byte present.
REQ-011 out_data  output  8  plaintext ASCII byte.
REQ-012 out_last  output  1  final plaintext byte of message.
REQ-013 out_ready  input  1  downstream accepts byte this cycle.
REQ-014 busy  output  1  high in RUN or DRAIN.
REQ-015 done  output  1  one-cycle pulse after last output byte is accepted.
REQ-016 key_error  output  1  latched high when the loaded key was out of range.
REQ-017 char_count  output  CNT_W  bytes accepted in current message.

Function
REQ-018 FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-019 IDLE: key_load=1 -> latch key, clear char_count, set key_error per REQ-020, go RUN; in_valid ignored, in_ready=0.
REQ-020 Valid key range 0..9; shift_value>9 -> key_error=1 and latched key=0 (pass-through); else key_error=0.
REQ-021 key_load outside IDLE is ignored.
REQ-022 Input handshake: byte transfers when in_valid && in_ready; in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-023 Single output register: accepted byte appears on out_data/out_valid the next cycle (latency 1); full throughput of one byte/cycle when out_ready stays high.
REQ-024 out_data/out_valid/out_last hold stable while out_valid && !out_ready.
REQ-025 Digits '0'..'9' (48..57): out = in - key; if result < 48, add 10.
REQ-026 Uppercase 'A'..'Z' (65..90): out = in - key; if result < 65, add 26.
REQ-027 Lowercase 'a'..'z' (97..122): out = in - key; if result < 97, add 26.
REQ-028 All other bytes pass unchanged; arithmetic done at 9 bits or wider so no underflow wrap below 0.
REQ-029 Decryption is the exact inverse of the team's shift encryptor for keys 0..9 on all 256 input values in the three ranges.
REQ-030 char_count increments on every input transfer, saturates at all-ones.
REQ-031 Input transfer with in_last=1 -> out_last=1 on that output byte, state RUN -> DRAIN.
REQ-032 DRAIN: in_ready=0; on output transfer with out_last -> IDLE, done=1 for one cycle.
REQ-033 Simultaneous output transfer and new input transfer in RUN: register reloads, out_valid stays 1.
REQ-034 char_count and key_error hold their values in IDLE until the next key_load.

Reset
REQ-035 rst=1 at any time forces immediately: state IDLE, out_valid=0, out_data=0, out_last=0, in_ready=0, busy=0, done=0, key_error=0, char_count=0, key=0.
REQ-036 Reset mid-message discards the output register contents; no done pulse is produced.
REQ-037 After rst deasserts, block waits for key_load before accepting data.

Verification
REQ-038 key 3, stream "KHOOR" (last on 'R'), out_ready=1 -> "HELLO" one cycle after each input, out_last on 'O', done pulse, char_count=5.
REQ-039 key 3, bytes 'A','a','1','!' -> 'X','x','8','!' (wrap-around and pass-through).
REQ-040 key 9, all 62 alphanumerics encrypted by the team's encryptor then fed here -> original bytes returned exactly.
REQ-041 out_ready held 0 for 4 cycles mid-stream -> in_ready=0, out_data stable, no byte lost or duplicated after release.
REQ-042 shift_value=12 on key_load -> key_error=1, "Zz9" passes unchanged.
REQ-043 rst asserted while out_valid=1 in RUN -> outputs cleared same cycle, in_valid ignored until new key_load.
